// File: rtl/frame_line_writer.sv
// frame_line_writer: raster pixel stream to line-banked BRAM write ports.
// Define FRAME_WR_CONT_EN for continuous mode, where DONE loops back to WRITE.
module frame_line_writer #(
    parameter int H_PIXELS       = 320,
    parameter int LINES_PER_BANK = 16,
    parameter int BANKS          = 15,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 12,
    parameter int BANK_WIDTH     = 4,
    parameter int X_WIDTH        = 9,
    parameter int Y_WIDTH        = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [X_WIDTH-1:0]    o_x,
    output logic [Y_WIDTH-1:0]    o_y,
    output logic [BANKS-1:0]      o_we,
    output logic [BANK_WIDTH-1:0] o_bank,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_frame_done
);
    localparam int LINE_WIDTH = $clog2(LINES_PER_BANK);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef FRAME_WR_CONT_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    logic [1:0]            state_q, state_d;
    logic [X_WIDTH-1:0]    x_q, x_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [BANK_WIDTH-1:0] bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [Y_WIDTH-1:0]    y_q, y_d;
    logic [BANKS-1:0]      we_q, we_d;
    logic [BANK_WIDTH-1:0] wbank_q, wbank_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  hs, clear, x_last, line_last, bank_last, line_end, bank_end, frame_end;

    always_comb begin
        hs        = i_valid && state_q == S_WRITE;
        clear     = i_start && state_q == S_IDLE;
        x_last    = x_q == X_WIDTH'(H_PIXELS - 1);
        line_last = line_q == LINE_WIDTH'(LINES_PER_BANK - 1);
        bank_last = bank_q == BANK_WIDTH'(BANKS - 1);
        line_end  = hs && x_last;
        bank_end  = line_end && line_last;
        frame_end = bank_end && bank_last;
        state_d   = clear ? S_WRITE :
                    frame_end ? S_DONE :
                    state_q == S_DONE ? (CONT_EN ? S_WRITE : S_IDLE) :
                    state_q == S_WRITE ? S_WRITE : S_IDLE;
        // addr continues across line ends, so it only resets at a bank boundary
        x_d       = clear || line_end ? '0 : hs ? x_q + X_WIDTH'(1) : x_q;
        line_d    = clear || bank_end ? '0 : line_end ? line_q + LINE_WIDTH'(1) : line_q;
        bank_d    = clear || frame_end ? '0 : bank_end ? bank_q + BANK_WIDTH'(1) : bank_q;
        addr_d    = clear || bank_end ? '0 : hs ? addr_q + ADDR_WIDTH'(1) : addr_q;
        y_d       = clear || frame_end ? '0 : line_end ? y_q + Y_WIDTH'(1) : y_q;
        we_d      = hs ? BANKS'(1) << bank_q : '0;
        wbank_d   = hs ? bank_q : wbank_q;
        waddr_d   = hs ? addr_q : waddr_q;
        wdata_d   = hs ? i_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            line_q  <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            y_q     <= '0;
            we_q    <= '0;
            wbank_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            line_q  <= line_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            y_q     <= y_d;
            we_q    <= we_d;
            wbank_q <= wbank_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_ready      = state_q == S_WRITE;
    assign o_busy       = state_q == S_WRITE || (CONT_EN && state_q == S_DONE);
    assign o_frame_done = state_q == S_DONE;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_we         = we_q;
    assign o_bank       = wbank_q;
    assign o_addr       = waddr_q;
    assign o_data       = wdata_q;
endmodule

// File: tb/tb_frame_line_writer.sv
// tb_frame_line_writer: scoreboard bench for frame_line_writer (full frame, gaps, mid-frame reset).
module tb_frame_line_writer;
`ifdef FRAME_WR_CONT_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_valid = 1'b0;
    logic [11:0] i_data = '0;
    logic        o_ready, o_busy, o_frame_done;
    logic [8:0]  o_x;
    logic [7:0]  o_y;
    logic [14:0] o_we;
    logic [3:0]  o_bank;
    logic [12:0] o_addr;
    logic [11:0] o_data;

    frame_line_writer dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_x(o_x), .o_y(o_y), .o_we(o_we), .o_bank(o_bank), .o_addr(o_addr),
        .o_data(o_data), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] we;
        logic [3:0]  bank;
        logic [12:0] addr;
        logic [11:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    int   mx = 0;
    int   my = 0;
    logic exp_done;
    logic gap_mode = 1'b0;

    // Engine model: data is x+y of the pixel it offers; valid optionally gapped.
    always @(posedge clk) begin
        #1;
        i_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        i_data  = 12'(o_x + o_y);
    end

    // Scoreboard: expectations pushed on each handshake, popped on each strobe.
    always @(negedge clk) begin
        exp_done = 1'b0;
        if (o_we != '0) begin
            strobes++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_strobe we=%h bank=%0d addr=%0d", o_we, o_bank, o_addr);
            end else begin
                e = sb.pop_front();
                exp_done = e.last;
                if ({o_we, o_bank, o_addr, o_data} !== {e.we, e.bank, e.addr, e.data}) begin
                    failures++;
                    $display("FAIL sb_write got we=%h bank=%0d addr=%0d data=%h exp we=%h bank=%0d addr=%0d data=%h",
                             o_we, o_bank, o_addr, o_data, e.we, e.bank, e.addr, e.data);
                end
            end
        end
        checks++;
        if (o_frame_done !== exp_done) begin
            failures++;
            $display("FAIL sb_frame_done got=%b exp=%b", o_frame_done, exp_done);
        end
        if (!i_rst_n) begin
            sb.delete();
            mx = 0;
            my = 0;
        end else if (o_ready) begin
            checks++;
            if (o_x !== 9'(mx) || o_y !== 8'(my)) begin
                failures++;
                $display("FAIL sb_coords got x=%0d y=%0d exp x=%0d y=%0d", o_x, o_y, mx, my);
            end
            if (i_valid) begin
                e.bank = 4'(my / 16);
                e.addr = 13'((my % 16) * 320 + mx);
                e.we   = 15'(1) << e.bank;
                e.data = i_data;
                e.last = mx == 319 && my == 239;
                sb.push_back(e);
                if (mx == 319) begin
                    mx = 0;
                    my = my == 239 ? 0 : my + 1;
                end else mx++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_hs(input int x, input int y, input int bound, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (o_ready && i_valid && o_x == 9'(x) && o_y == 8'(y)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for x=%0d y=%0d", name, x, y);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_ready, o_busy, o_frame_done, o_x, o_y, o_we, o_bank, o_addr, o_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b busy=%b done=%b x=%0d y=%0d we=%h bank=%0d addr=%0d data=%h",
                     o_ready, o_busy, o_frame_done, o_x, o_y, o_we, o_bank, o_addr, o_data);
        end
        i_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start ready=%b busy=%b exp 0 0", o_ready, o_busy);
        end
    endtask

    task automatic test_first_strobe();
        int n = 0;
        pulse_start();
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b1 || o_we !== '0) begin
            failures++;
            $display("FAIL start_write ready=%b busy=%b we=%h exp 1 1 0", o_ready, o_busy, o_we);
        end
        tick();
        checks++;
        if (o_we !== 15'h0001 || o_addr !== 13'd0 || o_bank !== 4'd0 || o_data !== 12'd0) begin
            failures++;
            $display("FAIL first_strobe we=%h addr=%0d bank=%0d data=%h exp 0001 0 0 000", o_we, o_addr, o_bank, o_data);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_we != '0) n++;
        end
        checks++;
        if (n != 50) begin
            failures++;
            $display("FAIL sustained_rate strobes=%0d exp 50", n);
        end
    endtask

    task automatic test_pixel_5_17();
        bit ok;
        wait_hs(5, 17, 6000, "pixel_5_17", ok);
        if (!ok) return;
        tick();
        checks++;
        if (o_bank !== 4'd1 || o_we !== 15'h0002 || o_addr !== 13'd325 || o_data !== 12'd22) begin
            failures++;
            $display("FAIL pixel_5_17 bank=%0d we=%h addr=%0d data=%0d exp 1 0002 325 22", o_bank, o_we, o_addr, o_data);
        end
    endtask

    task automatic test_gaps();
        logic [8:0] px;
        logic [7:0] py;
        logic       prev_hs = 1'b1;
        gap_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!prev_hs) begin
                checks++;
                if (o_x !== px || o_y !== py) begin
                    failures++;
                    $display("FAIL gap_frozen x=%0d y=%0d exp x=%0d y=%0d", o_x, o_y, px, py);
                end
            end
            prev_hs = o_ready && i_valid;
            px = o_x;
            py = o_y;
        end
        gap_mode = 1'b0;
    endtask

    task automatic test_last_pixel(input int s0);
        bit ok;
        wait_hs(319, 239, 80000, "last_pixel", ok);
        if (!ok) return;
        tick();
        checks++;
        if (o_bank !== 4'd14 || o_we !== 15'h4000 || o_addr !== 13'd5119 || o_frame_done !== 1'b1) begin
            failures++;
            $display("FAIL last_strobe bank=%0d we=%h addr=%0d done=%b exp 14 4000 5119 1", o_bank, o_we, o_addr, o_frame_done);
        end
        checks++;
        if (o_ready !== 1'b0 || o_busy !== CONT || o_x !== 9'd0 || o_y !== 8'd0) begin
            failures++;
            $display("FAIL done_state ready=%b busy=%b x=%0d y=%0d exp 0 %b 0 0", o_ready, o_busy, o_x, o_y, CONT);
        end
        checks++;
        if (strobes - s0 != 76800) begin
            failures++;
            $display("FAIL frame_strobe_count got=%0d exp 76800", strobes - s0);
        end
        tick();
        checks++;
        if (o_ready !== CONT || o_frame_done !== 1'b0 || o_we !== '0) begin
            failures++;
            $display("FAIL after_done ready=%b done=%b we=%h exp %b 0 0", o_ready, o_frame_done, o_we, CONT);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n = 0;
        if (!o_ready) pulse_start();
        wait_hs(0, 20, 8000, "mid_reset", ok);
        if (!ok) return;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        checks++;
        if (o_we !== '0 || o_busy !== 1'b0 || o_ready !== 1'b0 || o_x !== 9'd0 || o_y !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset we=%h busy=%b ready=%b x=%0d y=%0d exp all 0", o_we, o_busy, o_ready, o_x, o_y);
        end
        repeat (2) tick();
        pulse_start();
        for (int i = 0; i < 5 && o_we == '0; i++) tick();
        checks++;
        if (o_we !== 15'h0001 || o_bank !== 4'd0 || o_addr !== 13'd0) begin
            failures++;
            $display("FAIL restart we=%h bank=%0d addr=%0d exp 0001 0 0", o_we, o_bank, o_addr);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_we != '0) n++;
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL restart_rate strobes=%0d exp 20", n);
        end
    endtask

    initial begin
        int s0;
        test_reset();
        s0 = strobes;
        test_first_strobe();
        test_pixel_5_17();
        test_gaps();
        test_last_pixel(s0);
        test_mid_reset();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
